uart_core: RTL and testbench

Full-duplex 8N1 UART with one transmitter and one receiver that share a single clock and a compile-time bit period. It sits between the byte-level logic and the serial pins. The transmitter serialises a byte on a one-cycle strobe. The receiver oversamples the line, recovers bytes, and reports each with a one-cycle valid pulse. For self-test, `o_Tx_Serial` can be looped straight back to `i_Rx_Serial`.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx.sv | 140 ++++++++++++++
 rtl/uart_tx.sv | 147 ++++++++++++++
 rtl/uart_core.sv | 51 +++++
 tb/tb_uart_core.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the 8N1 UART: frame constants and the state
// encodings used by the transmitter and receiver machines.
package uart_pkg;

   localparam int   DATA_BITS = 8;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP,
      TX_DONE
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// uart_rx
// 8N1 receiver. The pin is synchronised through two flops, the start bit is
// confirmed at its midpoint, and each following bit is sampled one bit
// period later so sampling stays centred.
//
// Ports
//   i_Clock      sole clock, rising edge
//   i_Reset      synchronous active-high reset
//   i_Rx_Serial  asynchronous serial input
//   o_Rx_DV      one-cycle pulse when a byte with a good stop bit arrives
//   o_Rx_Byte    last good byte, held between pulses
//
// state    | meaning
// ---------+---------------------------------------------
// RX_IDLE  | line high, waiting for a falling edge
// RX_START | timing to mid start bit to reject glitches
// RX_DATA  | sampling data bits at mid-bit, LSB first
// RX_STOP  | sampling the stop bit; bad stop discards the byte
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte
);

   localparam int             CW          = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  LP_CNT_MAX  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]  LP_CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [2:0]     LP_IDX_LAST = 3'(DATA_BITS - 1);

   logic          r_Rx_Sync1;
   logic          r_Rx_Sync2;
   rx_state_t     r_State;
   logic [CW-1:0] r_Clk_Count;
   logic [2:0]    r_Bit_Index;
   logic [7:0]    r_Shift;
   logic [7:0]    r_Rx_Byte;
   logic          r_Rx_DV;

   logic          w_Rx_Bit;
   rx_state_t     w_Next_State;
   logic [CW-1:0] w_Next_Count;
   logic [2:0]    w_Next_Index;
   logic [7:0]    w_Next_Shift;
   logic [7:0]    w_Next_Byte;
   logic          w_Next_DV;

   assign w_Rx_Bit = r_Rx_Sync2;

   // Synchroniser resets to the idle level so a reset never fakes a start.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_Rx_Sync1  <= STOP_BIT;
         r_Rx_Sync2  <= STOP_BIT;
         r_State     <= RX_IDLE;
         r_Clk_Count <= '0;
         r_Bit_Index <= '0;
         r_Shift     <= '0;
         r_Rx_Byte   <= '0;
         r_Rx_DV     <= 1'b0;
      end else begin
         r_Rx_Sync1  <= i_Rx_Serial;
         r_Rx_Sync2  <= r_Rx_Sync1;
         r_State     <= w_Next_State;
         r_Clk_Count <= w_Next_Count;
         r_Bit_Index <= w_Next_Index;
         r_Shift     <= w_Next_Shift;
         r_Rx_Byte   <= w_Next_Byte;
         r_Rx_DV     <= w_Next_DV;
      end
   end

   always_comb begin
      w_Next_State = r_State;
      w_Next_Count = r_Clk_Count;
      w_Next_Index = r_Bit_Index;
      w_Next_Shift = r_Shift;
      w_Next_Byte  = r_Rx_Byte;
      w_Next_DV    = 1'b0;

      case (r_State)
         RX_IDLE: begin
            w_Next_Count = '0;
            w_Next_Index = '0;
            if (w_Rx_Bit == START_BIT) begin
               w_Next_State = RX_START;
            end
         end

         RX_START: begin
            if (r_Clk_Count == LP_CNT_HALF) begin
               w_Next_Count = '0;
               w_Next_State = (w_Rx_Bit == START_BIT) ? RX_DATA : RX_IDLE;
            end else begin
               w_Next_Count = r_Clk_Count + CW'(1);
            end
         end

         RX_DATA: begin
            if (r_Clk_Count == LP_CNT_MAX) begin
               w_Next_Count = '0;
               // Shift in from the top so the first bit ends up in bit 0.
               w_Next_Shift = {w_Rx_Bit, r_Shift[7:1]};
               w_Next_Index = r_Bit_Index + 3'd1;
               if (r_Bit_Index == LP_IDX_LAST) begin
                  w_Next_State = RX_STOP;
               end
            end else begin
               w_Next_Count = r_Clk_Count + CW'(1);
            end
         end

         RX_STOP: begin
            if (r_Clk_Count == LP_CNT_MAX) begin
               w_Next_Count = '0;
               w_Next_State = RX_IDLE;
               if (w_Rx_Bit == STOP_BIT) begin
                  w_Next_Byte = r_Shift;
                  w_Next_DV   = 1'b1;
               end
            end else begin
               w_Next_Count = r_Clk_Count + CW'(1);
            end
         end

         default: begin
            w_Next_State = RX_IDLE;
         end
      endcase
   end

   assign o_Rx_DV   = r_Rx_DV;
   assign o_Rx_Byte = r_Rx_Byte;

endmodule

// File: rtl/uart_tx.sv
// uart_tx
// 8N1 serialiser. A one-cycle i_Tx_DV in idle latches i_Tx_Byte and sends
// start, eight data bits LSB first and a stop bit, each CLKS_PER_BIT cycles.
//
// Ports
//   i_Clock      sole clock, rising edge
//   i_Reset      synchronous active-high reset
//   i_Tx_DV      one-cycle strobe qualifying i_Tx_Byte (ignored unless idle)
//   i_Tx_Byte    byte to send
//   o_Tx_Active  high while a frame is on the line
//   o_Tx_Serial  serial line, idles high
//   o_Tx_Done    one-cycle pulse after the stop bit
//
// state    | meaning
// ---------+---------------------------------------------
// TX_IDLE  | line high, waiting for a strobe
// TX_START | start bit (0) on the line
// TX_DATA  | data bit r_Bit_Index on the line
// TX_STOP  | stop bit (1) on the line
// TX_DONE  | single cycle that raises the done pulse
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Tx_DV,
   input  logic [7:0] i_Tx_Byte,
   output logic       o_Tx_Active,
   output logic       o_Tx_Serial,
   output logic       o_Tx_Done
);

   localparam int             CW          = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  LP_CNT_MAX  = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]     LP_IDX_LAST = 3'(DATA_BITS - 1);

   tx_state_t     r_State;
   logic [CW-1:0] r_Clk_Count;
   logic [2:0]    r_Bit_Index;
   logic [7:0]    r_Tx_Data;
   logic          r_Tx_Serial;
   logic          r_Tx_Active;
   logic          r_Tx_Done;

   tx_state_t     w_Next_State;
   logic [CW-1:0] w_Next_Count;
   logic [2:0]    w_Next_Index;
   logic [7:0]    w_Next_Data;
   logic          w_Tx_Serial;
   logic          w_Tx_Active;
   logic          w_Tx_Done;

   // Outputs are registered from the current state, so every line change
   // lands one edge after the state change that causes it.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_State     <= TX_IDLE;
         r_Clk_Count <= '0;
         r_Bit_Index <= '0;
         r_Tx_Data   <= '0;
         r_Tx_Serial <= STOP_BIT;
         r_Tx_Active <= 1'b0;
         r_Tx_Done   <= 1'b0;
      end else begin
         r_State     <= w_Next_State;
         r_Clk_Count <= w_Next_Count;
         r_Bit_Index <= w_Next_Index;
         r_Tx_Data   <= w_Next_Data;
         r_Tx_Serial <= w_Tx_Serial;
         r_Tx_Active <= w_Tx_Active;
         r_Tx_Done   <= w_Tx_Done;
      end
   end

   always_comb begin
      w_Next_State = r_State;
      w_Next_Count = r_Clk_Count;
      w_Next_Index = r_Bit_Index;
      w_Next_Data  = r_Tx_Data;
      w_Tx_Serial  = STOP_BIT;
      w_Tx_Active  = 1'b0;
      w_Tx_Done    = 1'b0;

      case (r_State)
         TX_IDLE: begin
            w_Next_Count = '0;
            w_Next_Index = '0;
            if (i_Tx_DV) begin
               w_Next_Data  = i_Tx_Byte;
               w_Next_State = TX_START;
            end
         end

         TX_START: begin
            w_Tx_Serial = START_BIT;
            w_Tx_Active = 1'b1;
            if (r_Clk_Count == LP_CNT_MAX) begin
               w_Next_Count = '0;
               w_Next_State = TX_DATA;
            end else begin
               w_Next_Count = r_Clk_Count + CW'(1);
            end
         end

         TX_DATA: begin
            w_Tx_Serial = r_Tx_Data[r_Bit_Index];
            w_Tx_Active = 1'b1;
            if (r_Clk_Count == LP_CNT_MAX) begin
               w_Next_Count = '0;
               w_Next_Index = r_Bit_Index + 3'd1;
               if (r_Bit_Index == LP_IDX_LAST) begin
                  w_Next_State = TX_STOP;
               end
            end else begin
               w_Next_Count = r_Clk_Count + CW'(1);
            end
         end

         TX_STOP: begin
            w_Tx_Serial = STOP_BIT;
            w_Tx_Active = 1'b1;
            if (r_Clk_Count == LP_CNT_MAX) begin
               w_Next_Count = '0;
               w_Next_State = TX_DONE;
            end else begin
               w_Next_Count = r_Clk_Count + CW'(1);
            end
         end

         TX_DONE: begin
            w_Tx_Done    = 1'b1;
            w_Next_State = TX_IDLE;
         end

         default: begin
            w_Next_State = TX_IDLE;
         end
      endcase
   end

   assign o_Tx_Serial = r_Tx_Serial;
   assign o_Tx_Active = r_Tx_Active;
   assign o_Tx_Done   = r_Tx_Done;

endmodule

// File: rtl/uart_core.sv
// uart_core
// Full-duplex 8N1 UART: one transmitter and one receiver sharing a clock
// and a compile-time bit period. Pure wiring of uart_tx and uart_rx.
//
// Ports
//   i_Clock, i_Reset                  clock and synchronous active-high reset
//   i_Tx_DV, i_Tx_Byte                transmit strobe and byte
//   o_Tx_Active, o_Tx_Serial,
//   o_Tx_Done                         transmitter status and line
//   i_Rx_Serial                       asynchronous receive line
//   o_Rx_DV, o_Rx_Byte                received byte and its valid pulse
module uart_core
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Tx_DV,
   input  logic [7:0] i_Tx_Byte,
   output logic       o_Tx_Active,
   output logic       o_Tx_Serial,
   output logic       o_Tx_Done,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte
);

   uart_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tx (
      .i_Clock     (i_Clock),
      .i_Reset     (i_Reset),
      .i_Tx_DV     (i_Tx_DV),
      .i_Tx_Byte   (i_Tx_Byte),
      .o_Tx_Active (o_Tx_Active),
      .o_Tx_Serial (o_Tx_Serial),
      .o_Tx_Done   (o_Tx_Done)
   );

   uart_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .i_Clock     (i_Clock),
      .i_Reset     (i_Reset),
      .i_Rx_Serial (i_Rx_Serial),
      .o_Rx_DV     (o_Rx_DV),
      .o_Rx_Byte   (o_Rx_Byte)
   );

endmodule

// File: tb/tb_uart_core.sv
module tb_uart_core;

   localparam int CPB = 87;

   logic       clk;
   logic       rst;
   logic       tx_dv;
   logic [7:0] tx_byte;
   logic       tx_active;
   logic       tx_serial;
   logic       tx_done;
   logic       rx_line;
   logic       rx_dv;
   logic [7:0] rx_byte;

   bit         loop_en;
   logic       rx_drv;

   int         checks;
   int         failures;
   int         cyc;
   int         dv_count;
   int         dv_cyc;
   int         done_count;
   int         done_cyc;
   logic [7:0] dv_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] exp_last;

   assign rx_line = loop_en ? tx_serial : rx_drv;

   uart_core #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .i_Clock     (clk),
      .i_Reset     (rst),
      .i_Tx_DV     (tx_dv),
      .i_Tx_Byte   (tx_byte),
      .o_Tx_Active (tx_active),
      .o_Tx_Serial (tx_serial),
      .o_Tx_Done   (tx_done),
      .i_Rx_Serial (rx_line),
      .o_Rx_DV     (rx_dv),
      .o_Rx_Byte   (rx_byte)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Event recorder: logs every DV pulse and Done pulse with its cycle.
   initial begin
      dv_count = 0; done_count = 0; dv_cyc = -1; done_cyc = -1;
   end
   always @(negedge clk) begin
      if (rx_dv === 1'b1) begin
         dv_q.push_back(rx_byte);
         dv_count = dv_count + 1;
         dv_cyc   = cyc;
      end
      if (tx_done === 1'b1) begin
         done_count = done_count + 1;
         done_cyc   = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Compare everything received so far against the expected byte stream.
   task automatic rx_compare(input string tag);
      chk({tag, "_rx_count"}, 32'(dv_q.size()), 32'(exp_q.size()));
      while (dv_q.size() > 0 && exp_q.size() > 0) begin
         chk({tag, "_rx_byte"}, 32'(dv_q.pop_front()), 32'(exp_q.pop_front()));
      end
      dv_q.delete();
      exp_q.delete();
   endtask

   task automatic strobe(input logic [7:0] b, output int k);
      @(negedge clk);
      tx_dv   = 1'b1;
      tx_byte = b;
      @(negedge clk);
      tx_dv   = 1'b0;
      tx_byte = 8'($urandom);
      k = cyc;
   endtask

   // Send one looped-back frame and check the whole line waveform against
   // the frame built from the byte: start 0, data LSB first, stop 1.
   task automatic tx_frame(input string tag, input logic [7:0] b, input bit inject);
      int k;
      int errs;
      int lat;
      logic [9:0] frame;
      frame = {1'b1, b, 1'b0};
      errs = 0;
      strobe(b, k);
      for (int t = 1; t <= 10 * CPB + 3; t++) begin
         @(negedge clk);
         if (inject && t == 3 * CPB) begin
            tx_dv = 1'b1; tx_byte = 8'h11;
         end else if (inject && t == 3 * CPB + 1) begin
            tx_dv = 1'b0;
         end
         if (t <= 10 * CPB) begin
            if (tx_serial !== frame[(t - 1) / CPB] || tx_active !== 1'b1 || tx_done !== 1'b0)
               errs++;
         end else if (t == 10 * CPB + 1) begin
            if (tx_active !== 1'b0 || tx_done !== 1'b1 || tx_serial !== 1'b1) errs++;
         end else begin
            if (tx_done !== 1'b0 || tx_serial !== 1'b1) errs++;
         end
      end
      exp_q.push_back(b);
      exp_last = b;
      chk({tag, "_wave_errs"}, 32'(errs), 32'd0);
      chk({tag, "_done_lat"}, 32'(done_cyc - k), 32'(10 * CPB + 1));
      lat = dv_cyc - (k + 1);
      chk({tag, "_rx_lat_ok"}, 32'((lat >= 827 && lat <= 830) ? 1 : 0), 32'd1);
      chk({tag, "_rx_hold"}, 32'(rx_byte), 32'(b));
   endtask

   task automatic rx_send(input logic [7:0] b, input logic stop_bit, output int c);
      logic [9:0] f;
      f = {stop_bit, b, 1'b0};
      @(negedge clk);
      c = cyc;
      for (int i = 0; i < 10; i++) begin
         rx_drv = f[i];
         repeat (CPB) @(negedge clk);
      end
      rx_drv = 1'b1;
   endtask

   task automatic wait_done(output int d, output bit ok);
      ok = 1'b0;
      d  = -1;
      for (int i = 0; i < 12 * CPB; i++) begin
         @(negedge clk);
         if (tx_done === 1'b1) begin
            ok = 1'b1; d = cyc; break;
         end
      end
   endtask

   initial begin
      int k1, k2, kd, kd2, c, errs, save_dv, save_done;
      bit ok;
      logic [7:0] b;

      checks = 0; failures = 0;
      rst = 1'b1; tx_dv = 1'b0; tx_byte = 8'h00;
      loop_en = 1'b1; rx_drv = 1'b1; exp_last = 8'h00;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_serial", 32'(tx_serial), 32'd1);
      chk("rst_active", 32'(tx_active), 32'd0);
      chk("rst_done",   32'(tx_done),   32'd0);
      chk("rst_dv",     32'(rx_dv),     32'd0);
      chk("rst_byte",   32'(rx_byte),   32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Loopback 0xAB and TX waveform for 0x01
      tx_frame("lb_ab", 8'hAB, 1'b0);
      rx_compare("lb_ab");
      tx_frame("wave_01", 8'h01, 1'b0);
      rx_compare("wave_01");

      // Random bytes through the loop
      for (int i = 0; i < 4; i++) begin
         tx_frame("rand", 8'($urandom), 1'b0);
         repeat (int'($urandom_range(1, 20))) @(negedge clk);
      end
      rx_compare("rand");

      // Back-to-back 0x00 then 0xFF, second strobe in the cycle after Done
      strobe(8'h00, k1);
      wait_done(kd, ok);
      chk("b2b_done1_seen", 32'(ok), 32'd1);
      chk("b2b_done1_lat", 32'(kd - k1), 32'(10 * CPB + 1));
      tx_dv = 1'b1; tx_byte = 8'hFF;
      @(negedge clk);
      tx_dv = 1'b0;
      k2 = cyc;
      chk("b2b_gap_line", 32'(tx_serial), 32'd1);
      @(negedge clk);
      chk("b2b_start_line", 32'(tx_serial), 32'd0);
      chk("b2b_start_active", 32'(tx_active), 32'd1);
      wait_done(kd2, ok);
      chk("b2b_done2_seen", 32'(ok), 32'd1);
      chk("b2b_done2_lat", 32'(kd2 - k2), 32'(10 * CPB + 1));
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      exp_last = 8'hFF;
      repeat (5) @(negedge clk);
      rx_compare("b2b");

      // Ignored strobe while active
      b = 8'($urandom);
      tx_frame("ign", b, 1'b1);
      save_dv = dv_count;
      errs = 0;
      for (int i = 0; i < 12 * CPB; i++) begin
         @(negedge clk);
         if (tx_active !== 1'b0 || tx_serial !== 1'b1) errs++;
      end
      chk("ign_no_frame", 32'(errs), 32'd0);
      chk("ign_no_dv", 32'(dv_count - save_dv), 32'd0);
      rx_compare("ign");

      // RX glitch and framing error with the pin driven directly
      loop_en = 1'b0;
      save_dv = dv_count;
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (20) @(negedge clk);
      rx_drv = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      chk("glitch_no_dv", 32'(dv_count - save_dv), 32'd0);

      rx_send(8'($urandom), 1'b0, c);
      repeat (3 * CPB) @(negedge clk);
      chk("frame_err_no_dv", 32'(dv_count - save_dv), 32'd0);
      chk("frame_err_hold", 32'(rx_byte), 32'(exp_last));

      for (int i = 0; i < 2; i++) begin
         b = 8'($urandom);
         rx_send(b, 1'b1, c);
         exp_q.push_back(b);
         exp_last = b;
         repeat (CPB) @(negedge clk);
         chk("rx_pin_lat_ok",
             32'(((dv_cyc - c) >= 827 && (dv_cyc - c) <= 830) ? 1 : 0), 32'd1);
      end
      rx_compare("rx_pin");
      loop_en = 1'b1;
      repeat (5) @(negedge clk);

      // Mid-frame reset during data bit 3
      save_dv   = dv_count;
      save_done = done_count;
      strobe(8'($urandom), k1);
      repeat (4 * CPB + 10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_line", 32'(tx_serial), 32'd1);
      chk("mrst_active", 32'(tx_active), 32'd0);
      errs = 0;
      for (int i = 0; i < 12 * CPB; i++) begin
         @(negedge clk);
         if (tx_serial !== 1'b1 || tx_active !== 1'b0) errs++;
      end
      chk("mrst_idle", 32'(errs), 32'd0);
      chk("mrst_no_done", 32'(done_count - save_done), 32'd0);
      chk("mrst_no_dv", 32'(dv_count - save_dv), 32'd0);
      chk("mrst_byte_cleared", 32'(rx_byte), 32'd0);
      dv_q.delete();
      exp_q.delete();
      tx_frame("mrst_5a", 8'h5A, 1'b0);
      rx_compare("mrst_5a");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
